gfx_fb_fetch: RTL and testbench
===============================

GFX_FB_FETCH -- requirements
Module: gfx_fb_fetch

Interface
REQ-001 SHALL have parameter PIXELS, default 307200, giving pixels per frame (one 16-bit memory word per pixel).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, a power of two ≥4, giving pixel FIFO entries.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk (input, 1, rising-edge clock) and rst_n (input, 1, reset), listed first.
REQ-004 SHALL have port vsync  input  1  one-cycle frame-start pulse.
REQ-005 SHALL have port fb_base  input  26  word address of the front buffer, sampled on vsync.
REQ-006 SHALL have ports mem_address  output  26, mem_read  output  1, mem_waitrequest  input  1, mem_readdatavalid  input  1 and mem_readdata  input  16, forming a pipelined Avalon-MM read master.
REQ-007 SHALL have ports pix_valid  output  1, pix_ready  input  1, pix_data  output  16, pix_startofframe  output  1 and pix_endofframe  output  1, forming the stream to scanout.
REQ-008 SHALL have port busy  output  1, high whenever the state is not IDLE.
REQ-009 SHALL have port abort_err  output  1, a sticky flag set when vsync aborts an unfinished frame.

Function
REQ-010 SHALL implement the states IDLE, FETCH and FLUSH.
REQ-011 IDLE + vsync SHALL: latch fb_base into base_q; clear issue_cnt and out_cnt; go to FETCH.
REQ-012 In FETCH, mem_read SHALL be asserted iff issue_cnt < PIXELS and pending + fifo_count < FIFO_DEPTH.
REQ-013 mem_address SHALL equal base_q + issue_cnt (26-bit wraparound, no carry out).
REQ-014 A read SHALL be accepted when mem_read && !mem_waitrequest; issue_cnt then increments by 1.
REQ-015 While mem_waitrequest is high, mem_address and mem_read SHALL be held stable.
REQ-016 pending SHALL increment on read accept and decrement on mem_readdatavalid; when both occur in one cycle, pending SHALL be unchanged.
REQ-017 pending and fifo_count SHALL never exceed FIFO_DEPTH (credit rule), so readdatavalid data is always stored and never dropped.
REQ-018 In FETCH, mem_readdata SHALL be pushed to the FIFO on mem_readdatavalid; a simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-019 pix_valid SHALL be high iff the FIFO is non-empty and the state is FETCH; pix_data SHALL be the FIFO head.
REQ-020 A pixel SHALL be popped when pix_valid && pix_ready; out_cnt then increments by 1.
REQ-021 pix_data, pix_startofframe and pix_endofframe SHALL be held stable while pix_valid is high and pix_ready is low.
REQ-022 pix_startofframe SHALL be high iff pix_valid and out_cnt == 0.
REQ-023 pix_endofframe SHALL be high iff pix_valid and out_cnt == PIXELS-1.
REQ-024 First-pixel latency SHALL be: read accepted in cycle N, readdatavalid in cycle M, pix_valid in cycle M+1 (registered FIFO).
REQ-025 FETCH SHALL go to IDLE in the cycle after the pop with out_cnt == PIXELS-1.
REQ-026 vsync in FETCH SHALL: set abort_err; deassert mem_read; flush the FIFO; go to FLUSH.
REQ-027 In FLUSH, returning readdatavalid data SHALL be discarded, and pix_valid and mem_read SHALL be 0.
REQ-028 FLUSH SHALL, when pending == 0, latch the fb_base value captured at the aborting vsync, clear the counters, and go to FETCH.
REQ-029 vsync in FLUSH SHALL update the captured base and keep abort_err set.
REQ-030 vsync coincident with the last pop SHALL be treated as an IDLE-entry vsync: no abort, with the new frame starting next cycle.
REQ-031 abort_err SHALL clear only on reset.

Reset
REQ-032 On rst_n low, asynchronously, the block SHALL: go to IDLE; zero all counters and the FIFO; drive mem_read, pix_valid, pix_startofframe, pix_endofframe, busy and abort_err to 0; drive mem_address to 0.
REQ-033 Reset mid-frame SHALL drop in-flight reads; readdatavalid arriving after reset release in IDLE SHALL be ignored.

Verification (PIXELS=8, FIFO_DEPTH=4)
REQ-034 Scenario: vsync with fb_base=0x100, no waitrequest, readdatavalid 2 cycles after accept, pix_ready=1 -> addresses 0x100..0x107 and data D0..D7 in order; SOF on D0, EOF on D7; busy falls one cycle after D7.
REQ-035 Scenario: pix_ready=0 throughout -> exactly 4 reads accepted, then mem_read=0; pix_data holds D0 with SOF=1.
REQ-036 Scenario: mem_waitrequest=1 for 3 cycles on the first read -> mem_address holds 0x100 and mem_read stays 1; the stream is otherwise unchanged.
REQ-037 Scenario: second vsync (fb_base=0x200) after 3 pixels are popped with 2 reads pending -> abort_err=1; both returns are discarded; the next frame reads 0x200..0x207 and SOF is on its first pixel.
REQ-038 Scenario: rst_n asserted with 3 reads pending -> all outputs are 0 immediately; late readdatavalid pulses produce no pix_valid.
REQ-039 Scenario: fb_base=0x3FFFFFE -> addresses 0x3FFFFFE, 0x3FFFFFF, 0x0000000 … 0x0000005.

Source files
------------

// File: rtl/gfx_fb_fetch_if.sv
// Bus bundle for the frame-buffer fetcher: pipelined Avalon-MM read master
// toward memory plus the valid/ready pixel stream toward scanout.
interface gfx_fb_fetch_if;
    logic [25:0] mem_address;
    logic        mem_read;
    logic        mem_waitrequest;
    logic        mem_readdatavalid;
    logic [15:0] mem_readdata;

    logic        pix_valid;
    logic        pix_ready;
    logic [15:0] pix_data;
    logic        pix_startofframe;
    logic        pix_endofframe;

    modport master (
        output mem_address,
        output mem_read,
        input  mem_waitrequest,
        input  mem_readdatavalid,
        input  mem_readdata,
        output pix_valid,
        input  pix_ready,
        output pix_data,
        output pix_startofframe,
        output pix_endofframe
    );

    modport slave (
        input  mem_address,
        input  mem_read,
        output mem_waitrequest,
        output mem_readdatavalid,
        output mem_readdata,
        input  pix_valid,
        output pix_ready,
        input  pix_data,
        input  pix_startofframe,
        input  pix_endofframe
    );
endinterface

// File: rtl/gfx_fb_fetch.sv
// Frame-buffer fetch engine: streams one frame of 16-bit pixels from memory through a
// credit-limited pipelined read master and a small registered pixel FIFO.
module gfx_fb_fetch #(
    parameter int unsigned PIXELS     = 307200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           vsync,
    input  logic [25:0]    fb_base,
    gfx_fb_fetch_if.master bus,
    output logic           busy,
    output logic           abort_err
);
    localparam int unsigned CntW  = $clog2(PIXELS + 1);
    localparam int unsigned CredW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam logic [CntW-1:0] PixTotal = CntW'(PIXELS);
    localparam logic [CntW-1:0] PixLast  = CntW'(PIXELS - 1);
    localparam logic [CredW:0]  Credits  = (CredW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StFetch, StFlush} state_e;

    state_e             state_q, state_d;
    logic [25:0]        base_q, base_d;
    logic [25:0]        cap_q, cap_d;
    logic [CntW-1:0]    issue_q, issue_d;
    logic [CntW-1:0]    out_q, out_d;
    logic [CredW-1:0]   pend_q, pend_d;
    logic [CredW-1:0]   cnt_q, cnt_d;
    logic [PtrW-1:0]    wr_q, wr_d;
    logic [PtrW-1:0]    rd_q, rd_d;
    logic               abort_q, abort_d;
    logic [15:0]        fifo_q [FIFO_DEPTH];

    logic start, abort, resume;
    logic rd_req, pix_vld, accept, pop, push, ret, last_pop, credit_ok;

    // Outstanding reads plus stored pixels never exceed the FIFO size, so returns always fit.
    assign credit_ok = ({1'b0, pend_q} + {1'b0, cnt_q}) < Credits;
    assign rd_req    = (state_q == StFetch) && (issue_q < PixTotal) && credit_ok;
    assign pix_vld   = (state_q == StFetch) && (cnt_q != '0);
    assign accept    = rd_req && !bus.mem_waitrequest;
    assign pop       = pix_vld && bus.pix_ready;
    assign push      = (state_q == StFetch) && bus.mem_readdatavalid;
    assign ret       = bus.mem_readdatavalid && (pend_q != '0);
    assign last_pop  = pop && (out_q == PixLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        abort   = 1'b0;
        resume  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (vsync) begin
                    state_d = StFetch;
                    start   = 1'b1;
                end
            end
            StFetch: begin
                // A vsync landing on the final pop is a clean frame boundary, not an abort.
                if (vsync && last_pop) begin
                    start = 1'b1;
                end else if (vsync) begin
                    state_d = StFlush;
                    abort   = 1'b1;
                end else if (last_pop) begin
                    state_d = StIdle;
                end
            end
            StFlush: begin
                if (pend_q == '0) begin
                    state_d = StFetch;
                    resume  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy                 = (state_q != StIdle);
        abort_err            = abort_q;
        bus.mem_read         = rd_req;
        bus.mem_address      = base_q + 26'(issue_q);
        bus.pix_valid        = pix_vld;
        bus.pix_data         = fifo_q[rd_q];
        bus.pix_startofframe = pix_vld && (out_q == '0);
        bus.pix_endofframe   = pix_vld && (out_q == PixLast);
    end

    always_comb begin
        base_d  = base_q;
        cap_d   = cap_q;
        issue_d = issue_q;
        out_d   = out_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        abort_d = abort_q;
        if (accept && !ret) begin
            pend_d = pend_q + CredW'(1);
        end else if (!accept && ret) begin
            pend_d = pend_q - CredW'(1);
        end
        if (accept) issue_d = issue_q + CntW'(1);
        if (push) wr_d = wr_q + PtrW'(1);
        if (pop) begin
            rd_d  = rd_q + PtrW'(1);
            out_d = out_q + CntW'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CredW'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CredW'(1);
        end
        if ((state_q == StFlush) && vsync) cap_d = fb_base;
        if (abort) begin
            cap_d   = fb_base;
            abort_d = 1'b1;
            wr_d    = '0;
            rd_d    = '0;
            cnt_d   = '0;
        end
        if (start || resume) begin
            base_d  = (start || vsync) ? fb_base : cap_q;
            issue_d = '0;
            out_d   = '0;
            wr_d    = '0;
            rd_d    = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q  <= '0;
            cap_q   <= '0;
            issue_q <= '0;
            out_q   <= '0;
            pend_q  <= '0;
            cnt_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            abort_q <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            base_q  <= base_d;
            cap_q   <= cap_d;
            issue_q <= issue_d;
            out_q   <= out_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            abort_q <= abort_d;
            if (push && !abort) fifo_q[wr_q] <= bus.mem_readdata;
        end
    end
endmodule

// File: tb/tb_gfx_fb_fetch.sv
// Self-checking bench for gfx_fb_fetch: memory slave model with fixed read latency and a
// scoreboard of expected addresses and pixels.
module tb_gfx_fb_fetch;
    localparam int unsigned PIX   = 8;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vsync = 1'b0;
    logic [25:0] fb_base = '0;
    logic        busy;
    logic        abort_err;

    gfx_fb_fetch_if bus_if ();

    gfx_fb_fetch #(
        .PIXELS    (PIX),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .vsync    (vsync),
        .fb_base  (fb_base),
        .bus      (bus_if),
        .busy     (busy),
        .abort_err(abort_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        int          idx;
        logic        drop;
        int          cd;
    } resp_t;

    typedef struct {
        logic [15:0] data;
        logic        sof;
        logic        eof;
    } pix_t;

    resp_t resp_q[$];
    pix_t  exp_q[$];
    resp_t r_mon;
    pix_t  e_mon;

    int tests = 0;
    int fails = 0;
    int lat = 2;
    int wait_left = 0;
    int stalls = 0;
    int accepts = 0;
    int pops = 0;
    int eofs = 0;
    logic        expect_abort = 1'b0;
    logic [25:0] exp_base = '0;
    int          exp_idx = 0;
    logic [25:0] exp_addr;

    logic        prev_mr_wait = 1'b0, prev_stall = 1'b0, prev_eof_pop = 1'b0, prev_vsync = 1'b0;
    logic [25:0] prev_addr = '0;
    logic [15:0] prev_data = '0;
    logic        prev_sof = 1'b0, prev_eof = 1'b0;

    function automatic logic [15:0] mem_fn(input logic [25:0] a);
        return a[15:0] ^ 16'h5A5A ^ {6'd0, a[25:16]};
    endfunction

    // Memory slave, scoreboard and protocol monitor; all sampling happens on the falling edge.
    always @(negedge clk) begin
        foreach (resp_q[i]) resp_q[i].cd = resp_q[i].cd - 1;
        bus_if.mem_readdatavalid = 1'b0;
        bus_if.mem_readdata      = 16'hDEAD;
        if (resp_q.size() > 0 && resp_q[0].cd <= 0) begin
            r_mon = resp_q.pop_front();
            bus_if.mem_readdatavalid = 1'b1;
            bus_if.mem_readdata      = r_mon.data;
            if (!r_mon.drop) begin
                e_mon.data = r_mon.data;
                e_mon.sof  = (r_mon.idx == 0);
                e_mon.eof  = (r_mon.idx == PIX - 1);
                exp_q.push_back(e_mon);
            end
        end
        bus_if.mem_waitrequest = 1'b0;
        if (rst_n) begin
            if (bus_if.mem_read && wait_left > 0) begin
                bus_if.mem_waitrequest = 1'b1;
                wait_left--;
                stalls++;
            end
            if (prev_mr_wait && !prev_vsync) begin
                tests++;
                if (bus_if.mem_read !== 1'b1 || bus_if.mem_address !== prev_addr) begin
                    fails++;
                    $display("FAIL wait_hold: read %b addr %h, need read 1 addr %h",
                             bus_if.mem_read, bus_if.mem_address, prev_addr);
                end
            end
            if (bus_if.mem_read && !bus_if.mem_waitrequest) begin
                exp_addr = 26'(exp_base + 26'(exp_idx));
                tests++;
                if (bus_if.mem_address !== exp_addr) begin
                    fails++;
                    $display("FAIL addr: got %h want %h", bus_if.mem_address, exp_addr);
                end
                r_mon.data = mem_fn(exp_addr);
                r_mon.idx  = exp_idx;
                r_mon.drop = 1'b0;
                r_mon.cd   = lat;
                resp_q.push_back(r_mon);
                exp_idx++;
                accepts++;
            end
            if (prev_stall && !prev_vsync) begin
                tests++;
                if (bus_if.pix_valid !== 1'b1 || bus_if.pix_data !== prev_data ||
                    bus_if.pix_startofframe !== prev_sof || bus_if.pix_endofframe !== prev_eof) begin
                    fails++;
                    $display("FAIL pix_hold: valid %b data %h sof %b eof %b, need 1 %h %b %b",
                             bus_if.pix_valid, bus_if.pix_data, bus_if.pix_startofframe,
                             bus_if.pix_endofframe, prev_data, prev_sof, prev_eof);
                end
            end
            if (bus_if.pix_valid && bus_if.pix_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL pix_unexpected: got data %h, want no pixel", bus_if.pix_data);
                end else begin
                    e_mon = exp_q.pop_front();
                    if (bus_if.pix_data !== e_mon.data || bus_if.pix_startofframe !== e_mon.sof ||
                        bus_if.pix_endofframe !== e_mon.eof) begin
                        fails++;
                        $display("FAIL pix: got data %h sof %b eof %b, want %h %b %b",
                                 bus_if.pix_data, bus_if.pix_startofframe,
                                 bus_if.pix_endofframe, e_mon.data, e_mon.sof, e_mon.eof);
                    end
                end
                pops++;
                if (bus_if.pix_endofframe) eofs++;
            end
            if (prev_eof_pop && !prev_vsync) begin
                tests++;
                if (busy !== 1'b0) begin
                    fails++;
                    $display("FAIL busy_fall: got %b want 0", busy);
                end
            end
            if (vsync) begin
                if (expect_abort) begin
                    foreach (resp_q[i]) resp_q[i].drop = 1'b1;
                    exp_q.delete();
                end
                exp_base = fb_base;
                exp_idx  = 0;
            end
            prev_mr_wait = bus_if.mem_read && bus_if.mem_waitrequest;
            prev_addr    = bus_if.mem_address;
            prev_stall   = bus_if.pix_valid && !bus_if.pix_ready;
            prev_data    = bus_if.pix_data;
            prev_sof     = bus_if.pix_startofframe;
            prev_eof     = bus_if.pix_endofframe;
            prev_eof_pop = bus_if.pix_valid && bus_if.pix_ready && bus_if.pix_endofframe;
            prev_vsync   = vsync;
        end else begin
            prev_mr_wait = 1'b0;
            prev_stall   = 1'b0;
            prev_eof_pop = 1'b0;
            prev_vsync   = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_vsync(input logic [25:0] b, input logic ab);
        fb_base      = b;
        expect_abort = ab;
        vsync        = 1'b1;
        step();
        vsync        = 1'b0;
        expect_abort = 1'b0;
    endtask

    task automatic wait_frame(input int target);
        int n = 0;
        while (eofs < target && n < 200) begin
            step();
            n++;
        end
        tests++;
        if (eofs < target) begin
            fails++;
            $display("FAIL frame_timeout: eof count %0d, need %0d", eofs, target);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        bus_if.pix_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        tests++;
        if ({busy, abort_err, bus_if.mem_read, bus_if.pix_valid, bus_if.pix_startofframe,
             bus_if.pix_endofframe} !== 6'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b want 000000", {busy, abort_err, bus_if.mem_read,
                     bus_if.pix_valid, bus_if.pix_startofframe, bus_if.pix_endofframe});
        end
        tests++;
        if (bus_if.mem_address !== 26'h0) begin
            fails++;
            $display("FAIL reset_addr: got %h want 0", bus_if.mem_address);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_basic();
        int a0 = accepts;
        int p0 = pops;
        int e0 = eofs;
        bus_if.pix_ready = 1'b1;
        pulse_vsync(26'h100, 1'b0);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_busy: got %b want 1", busy);
        end
        wait_frame(e0 + 1);
        step();
        step();
        tests++;
        if (accepts - a0 != 8 || pops - p0 != 8) begin
            fails++;
            $display("FAIL basic_counts: reads %0d pixels %0d, want 8 8", accepts - a0, pops - p0);
        end
        tests++;
        if (exp_q.size() != 0 || resp_q.size() != 0 || abort_err !== 1'b0) begin
            fails++;
            $display("FAIL basic_drain: exp %0d resp %0d abort %b, want 0 0 0",
                     exp_q.size(), resp_q.size(), abort_err);
        end
    endtask

    task automatic test_backpressure();
        int a0 = accepts;
        int e0 = eofs;
        bus_if.pix_ready = 1'b0;
        pulse_vsync(26'h100, 1'b0);
        repeat (15) step();
        tests++;
        if (accepts - a0 != 4 || bus_if.mem_read !== 1'b0) begin
            fails++;
            $display("FAIL bp_credit: reads %0d mem_read %b, want 4 0",
                     accepts - a0, bus_if.mem_read);
        end
        tests++;
        if (bus_if.pix_valid !== 1'b1 || bus_if.pix_data !== mem_fn(26'h100) ||
            bus_if.pix_startofframe !== 1'b1) begin
            fails++;
            $display("FAIL bp_head: valid %b data %h sof %b, want 1 %h 1",
                     bus_if.pix_valid, bus_if.pix_data, bus_if.pix_startofframe, mem_fn(26'h100));
        end
        bus_if.pix_ready = 1'b1;
        wait_frame(e0 + 1);
        step();
    endtask

    task automatic test_waitreq();
        int a0 = accepts;
        int e0 = eofs;
        stalls = 0;
        wait_left = 3;
        bus_if.pix_ready = 1'b1;
        pulse_vsync(26'h100, 1'b0);
        wait_frame(e0 + 1);
        step();
        tests++;
        if (stalls != 3 || accepts - a0 != 8) begin
            fails++;
            $display("FAIL waitreq: stalls %0d reads %0d, want 3 8", stalls, accepts - a0);
        end
    endtask

    task automatic test_eof_vsync();
        int n = 0;
        int p0 = pops;
        int e0 = eofs;
        bus_if.pix_ready = 1'b1;
        pulse_vsync(26'h100, 1'b0);
        while (!(bus_if.pix_valid && bus_if.pix_endofframe) && n < 100) begin
            step();
            n++;
        end
        tests++;
        if (n >= 100) begin
            fails++;
            $display("FAIL eofv_timeout: no end-of-frame pixel seen, want one");
        end
        pulse_vsync(26'h180, 1'b0);
        tests++;
        if (busy !== 1'b1 || abort_err !== 1'b0) begin
            fails++;
            $display("FAIL eofv_restart: busy %b abort %b, want 1 0", busy, abort_err);
        end
        wait_frame(e0 + 2);
        step();
        tests++;
        if (pops - p0 != 16 || abort_err !== 1'b0) begin
            fails++;
            $display("FAIL eofv_frames: pixels %0d abort %b, want 16 0", pops - p0, abort_err);
        end
    endtask

    task automatic test_wrap();
        int a0 = accepts;
        int e0 = eofs;
        bus_if.pix_ready = 1'b1;
        pulse_vsync(26'h3FFFFFE, 1'b0);
        wait_frame(e0 + 1);
        step();
        tests++;
        if (accepts - a0 != 8 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL wrap: reads %0d leftover %0d, want 8 0", accepts - a0, exp_q.size());
        end
    endtask

    task automatic test_abort();
        int n = 0;
        int p0 = pops;
        int e0 = eofs;
        bus_if.pix_ready = 1'b1;
        pulse_vsync(26'h100, 1'b0);
        while (pops - p0 < 3 && n < 100) begin
            step();
            n++;
        end
        tests++;
        if (resp_q.size() != 2) begin
            fails++;
            $display("FAIL abort_pending: in flight %0d, want 2", resp_q.size());
        end
        bus_if.pix_ready = 1'b0;
        pulse_vsync(26'h200, 1'b1);
        tests++;
        if (abort_err !== 1'b1 || bus_if.mem_read !== 1'b0 || bus_if.pix_valid !== 1'b0) begin
            fails++;
            $display("FAIL abort_flush: abort %b read %b valid %b, want 1 0 0",
                     abort_err, bus_if.mem_read, bus_if.pix_valid);
        end
        bus_if.pix_ready = 1'b1;
        wait_frame(e0 + 1);
        step();
        step();
        tests++;
        if (pops - p0 != 11 || exp_q.size() != 0 || abort_err !== 1'b1) begin
            fails++;
            $display("FAIL abort_next: pixels %0d leftover %0d abort %b, want 11 0 1",
                     pops - p0, exp_q.size(), abort_err);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int a0 = accepts;
        lat = 3;
        bus_if.pix_ready = 1'b0;
        pulse_vsync(26'h100, 1'b0);
        while (accepts - a0 < 3 && n < 100) begin
            step();
            n++;
        end
        tests++;
        if (resp_q.size() != 3) begin
            fails++;
            $display("FAIL rst_pending: in flight %0d, want 3", resp_q.size());
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({busy, abort_err, bus_if.mem_read, bus_if.pix_valid, bus_if.pix_startofframe,
             bus_if.pix_endofframe} !== 6'b0 || bus_if.mem_address !== 26'h0) begin
            fails++;
            $display("FAIL rst_mid: flags %b addr %h, want 000000 0", {busy, abort_err,
                     bus_if.mem_read, bus_if.pix_valid, bus_if.pix_startofframe,
                     bus_if.pix_endofframe}, bus_if.mem_address);
        end
        foreach (resp_q[i]) resp_q[i].drop = 1'b1;
        exp_q.delete();
        step();
        rst_n = 1'b1;
        bus_if.pix_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            tests++;
            if (bus_if.pix_valid !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL rst_late: valid %b busy %b, want 0 0", bus_if.pix_valid, busy);
            end
        end
        tests++;
        if (resp_q.size() != 0) begin
            fails++;
            $display("FAIL rst_drain: in flight %0d, want 0", resp_q.size());
        end
        lat = 2;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_waitreq();
        test_eof_vsync();
        test_wrap();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1);
    end
endmodule
